mc_control_fsm: RTL and testbench

Parametrised multi-cycle RV32I control unit. It sequences fetch, decode, execute, memory and write-back for one instruction at a time, and drives datapath select, write-enable and byte-enable signals. Unlike the fixed-latency control unit, memory states use a req/ready handshake with variable latency, and an optional timeout. Undefined opcodes, undefined load/store widths and undefined branch funct3 values are trapped into a sticky fault state. The block sits between the instruction register / opcode decode and the multi-cycle datapath (PC, register file, ALU, unified memory).

---
 rtl/mc_control_fsm.sv | 248 ++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit with req/ready memory handshake and sticky fault trapping.
// Optional memory wait timeout is enabled by defining MC_CONTROL_TIMEOUT_EN.
module mc_control_fsm #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255,
  parameter int BE_W        = 4
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic            ir_write,
  output logic            pc_write,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            alu_src1,
  output logic            alu_src2,
  output logic            jump,
  output logic            branch,
  output logic            jal_or_jalr,
  output logic [6:0]      alu_op,
  output logic [2:0]      concat_ctrl,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic            retire,
  output logic [4:0]      state
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [4:0] {
    S_FETCH = 5'd0,  S_DECODE = 5'd1,  S_MADDR = 5'd2,  S_MRD   = 5'd3,
    S_MWB   = 5'd4,  S_MWR    = 5'd5,  S_REX   = 5'd6,  S_AWB   = 5'd7,
    S_BR    = 5'd8,  S_JAL    = 5'd9,  S_JALR  = 5'd10, S_JWB   = 5'd11,
    S_IEX   = 5'd12, S_UEX    = 5'd13, S_LUIWB = 5'd14, S_AUIWB = 5'd15,
    S_FAULT = 5'd16
  } state_t;

  state_t     state_q, state_d;
  logic       fault_q;
  logic [1:0] cause_q, cause_d;
  logic       timeout;
  logic       load_bad, store_bad, br_bad;

  if (TIMEOUT_MAX > (1 << TIMEOUT_W) - 1) begin : g_bad_timeout_cfg
    $error("TIMEOUT_MAX does not fit in TIMEOUT_W bits");
  end

  // Byte lanes from the access width; signedness of loads does not affect lanes.
  function automatic logic [BE_W-1:0] lane_mask(input logic [2:0] f3);
    logic [BE_W-1:0] m;
    m = '0;
    case (f3)
      3'd0, 3'd4: m[0]   = 1'b1;
      3'd1, 3'd5: m[1:0] = 2'b11;
      3'd2:       m[3:0] = 4'hF;
      default:    m      = '0;
    endcase
    return m;
  endfunction

  assign load_bad  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
  assign store_bad = (funct3 >= 3'd3);
  assign br_bad    = (funct3 == 3'd2) || (funct3 == 3'd3);

`ifdef MC_CONTROL_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(TIMEOUT_MAX);
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 wait_state;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR);
  assign timeout    = wait_state && !mem_ready && (wait_cnt == CNT_MAX);

  always_ff @(posedge CLK) begin
    if (!RSTn)
      wait_cnt <= '0;
    else if (wait_state && !mem_ready && (state_d == state_q))
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= S_FETCH;
      fault_q <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if ((state_q != S_FAULT) && (state_d == S_FAULT)) begin
        fault_q <= 1'b1;
        cause_q <= cause_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = 2'd0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MADDR;
          OP_REG:            state_d = S_REX;
          OP_BRANCH:         state_d = S_BR;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_IMM:            state_d = S_IEX;
          OP_LUI, OP_AUIPC:  state_d = S_UEX;
          default: begin
            state_d = S_FAULT;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MADDR: begin
        if ((opcode == OP_LOAD) ? load_bad : store_bad) begin
          state_d = S_FAULT;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = (opcode == OP_LOAD) ? S_MRD : S_MWR;
        end
      end
      S_MRD:   if (mem_ready) state_d = S_MWB;
      S_MWR:   if (mem_ready) state_d = S_FETCH;
      S_MWB, S_AWB, S_JWB, S_LUIWB, S_AUIWB: state_d = S_FETCH;
      S_REX, S_IEX: state_d = S_AWB;
      S_UEX:   state_d = (opcode == OP_LUI) ? S_LUIWB : S_AUIWB;
      S_BR: begin
        if (br_bad) begin
          state_d = S_FAULT;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_JAL, S_JALR: state_d = S_JWB;
      S_FAULT: state_d = S_FAULT;
      default: begin
        state_d = S_FAULT;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
    if (timeout) begin
      state_d = S_FAULT;
      cause_d = CAUSE_TIMEOUT;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_be      = '0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src1    = 1'b0;
    alu_src2    = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    jal_or_jalr = 1'b0;
    concat_ctrl = 3'd0;
    retire      = 1'b0;
    alu_op      = ((state_q == S_FETCH) || (state_q == S_FAULT)) ? 7'd0 : opcode;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_be   = '1;
        ir_write = mem_ready;
      end
      S_MADDR: begin
        alu_src2    = 1'b1;
        concat_ctrl = (opcode == OP_LOAD) ? 3'd3 : 3'd5;
      end
      S_MRD: begin
        mem_req = 1'b1;
        mem_be  = lane_mask(funct3);
      end
      S_MWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_be   = lane_mask(funct3);
        pc_write = mem_ready;
        retire   = mem_ready;
      end
      S_MWB, S_AWB, S_JWB, S_LUIWB, S_AUIWB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        mem_to_reg = (state_q == S_MWB);
        jump       = (state_q == S_JWB);
      end
      S_IEX: begin
        alu_src2    = 1'b1;
        concat_ctrl = ((funct3 == 3'd1) || (funct3 == 3'd5)) ? 3'd6 : 3'd3;
      end
      S_UEX: begin
        alu_src1    = 1'b1;
        alu_src2    = 1'b1;
        concat_ctrl = 3'd1;
      end
      S_BR: begin
        concat_ctrl = 3'd4;
        branch      = 1'b1;
        pc_write    = !br_bad;
        retire      = !br_bad;
      end
      S_JAL: begin
        alu_src1    = 1'b1;
        alu_src2    = 1'b1;
        concat_ctrl = 3'd2;
        jump        = 1'b1;
      end
      S_JALR: begin
        alu_src2    = 1'b1;
        concat_ctrl = 3'd3;
        jump        = 1'b1;
        jal_or_jalr = 1'b1;
      end
      default: ;
    endcase
  end

  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: table vectors, corner sequences and random instructions
// checked cycle by cycle against an instruction-level path model.
module tb_mc_control_fsm;
  localparam int BE_W = 4;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic            mem_ready = 1'b0;
  logic            mem_req, mem_we, ir_write, pc_write, reg_write, mem_to_reg;
  logic            alu_src1, alu_src2, jump, branch, jal_or_jalr, fault, retire;
  logic [BE_W-1:0] mem_be;
  logic [6:0]      alu_op;
  logic [2:0]      concat_ctrl;
  logic [1:0]      fault_cause;
  logic [4:0]      state;

  mc_control_fsm #(.TIMEOUT_W(8), .TIMEOUT_MAX(4), .BE_W(BE_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .jump(jump), .branch(branch),
    .jal_or_jalr(jal_or_jalr), .alu_op(alu_op), .concat_ctrl(concat_ctrl),
    .fault(fault), .fault_cause(fault_cause), .retire(retire), .state(state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int n_ret, n_rw, n_cyc;
  int path[$];

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    int         wf;
    int         wm;
    int         hold;
    int         exp_cycles;
    bit         exp_fault;
  } vec_t;
  vec_t vecs[$];

  // Instruction class decides the sequence of states visited (16 = trapped).
  function automatic void build_path(input logic [6:0] opc, input logic [2:0] f3);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (opc)
      7'h03: begin path.push_back(2); if (f3 == 3 || f3 == 6 || f3 == 7) path.push_back(16);
                   else begin path.push_back(3); path.push_back(4); end end
      7'h23: begin path.push_back(2); path.push_back(f3 >= 3 ? 16 : 5); end
      7'h33: begin path.push_back(6); path.push_back(7); end
      7'h63: begin path.push_back(8); if (f3 == 2 || f3 == 3) path.push_back(16); end
      7'h6F: begin path.push_back(9); path.push_back(11); end
      7'h67: begin path.push_back(10); path.push_back(11); end
      7'h13: begin path.push_back(12); path.push_back(7); end
      7'h37: begin path.push_back(13); path.push_back(14); end
      7'h17: begin path.push_back(13); path.push_back(15); end
      default: path.push_back(16);
    endcase
  endfunction

  // Required output word for a state: {req,we,be,irw,pcw,rw,m2r,s1,s2,j,br,jj,aluop,concat,fault,cause,retire}
  function automatic logic [28:0] exp_out(input int st, input logic [6:0] opc, input logic [2:0] f3,
                                          input logic rdy, input logic [1:0] cause);
    logic req, we, irw, pcw, rw, m2r, s1, s2, j, br, jj, flt, ret;
    logic [3:0] be;
    logic [6:0] aop;
    logic [2:0] cc;
    logic [1:0] cs;
    {req, we, irw, pcw, rw, m2r, s1, s2, j, br, jj, flt, ret} = '0;
    be = 4'h0; cc = 3'd0; cs = 2'd0;
    aop = (st == 0 || st == 16) ? 7'd0 : opc;
    case (st)
      0: begin req = 1; be = 4'hF; irw = rdy; end
      2: begin s2 = 1; cc = (opc == 7'h03) ? 3'd3 : 3'd5; end
      3, 5: begin
        req = 1; we = (st == 5);
        be = (f3[1:0] == 2'd0) ? 4'h1 : (f3[1:0] == 2'd1) ? 4'h3 : (f3[1:0] == 2'd2) ? 4'hF : 4'h0;
        if (st == 5) begin pcw = rdy; ret = rdy; end
      end
      4, 7, 11, 14, 15: begin rw = 1; pcw = 1; ret = 1; m2r = (st == 4); j = (st == 11); end
      8: begin cc = 3'd4; br = 1; pcw = !(f3 == 2 || f3 == 3); ret = pcw; end
      9: begin s1 = 1; s2 = 1; cc = 3'd2; j = 1; end
      10: begin s2 = 1; cc = 3'd3; j = 1; jj = 1; end
      12: begin s2 = 1; cc = (f3 == 1 || f3 == 5) ? 3'd6 : 3'd3; end
      13: begin s1 = 1; s2 = 1; cc = 3'd1; end
      16: begin flt = 1; cs = cause; end
      default: ;
    endcase
    return {req, we, be, irw, pcw, rw, m2r, s1, s2, j, br, jj, aop, cc, flt, cs, ret};
  endfunction

  task automatic do_cycle(input int st, input logic rdy, input logic [1:0] cause);
    logic [28:0] act, expv;
    mem_ready = rdy;
    #1;
    expv = exp_out(st, opcode, funct3, rdy, cause);
    act = {mem_req, mem_we, mem_be, ir_write, pc_write, reg_write, mem_to_reg, alu_src1, alu_src2,
           jump, branch, jal_or_jalr, alu_op, concat_ctrl, fault, fault_cause, retire};
    checks++;
    if (state !== 5'(st) || act !== expv) begin
      errors++;
      $display("FAIL cycle op=%h f3=%0d: state=%0d outs=%h, required state=%0d outs=%h",
               opcode, funct3, state, act, st, expv);
    end
    n_ret += int'(retire);
    n_rw  += int'(reg_write);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input int wf, input int wm,
                           input int hold, output bit faulted);
    int nw;
    bit mem_st;
    opcode = opc;
    funct3 = f3;
    build_path(opc, f3);
    n_ret = 0; n_rw = 0; n_cyc = 0; faulted = 0;
    foreach (path[i]) begin
      if (path[i] == 16) begin
        faulted = 1;
        break;
      end
      mem_st = (path[i] == 0 || path[i] == 3 || path[i] == 5);
      nw = (path[i] == 0) ? wf : (path[i] == 3 || path[i] == 5) ? wm : 0;
      for (int k = 0; k <= nw; k++) begin
        do_cycle(path[i], mem_st ? (k == nw) : 1'($urandom_range(0, 1)), 2'd0);
        n_cyc++;
      end
    end
    if (faulted)
      for (int k = 0; k < hold; k++) do_cycle(16, 1'($urandom_range(0, 1)), 2'd1);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bit flt;
    logic [6:0] ops [9];
    logic [6:0] op;
    logic [2:0] f3;
    int idx;
    ops = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h13, 7'h37, 7'h17};

    vecs.push_back('{7'h33, 3'd0, 0, 0, 0,  4, 1'b0});  // ADD
    vecs.push_back('{7'h03, 3'd2, 3, 2, 0, 10, 1'b0});  // LW with waits
    vecs.push_back('{7'h23, 3'd0, 0, 0, 0,  4, 1'b0});  // SB
    vecs.push_back('{7'h7F, 3'd0, 0, 0, 20, 2, 1'b1});  // undefined opcode
    vecs.push_back('{7'h17, 3'd0, 0, 0, 0,  4, 1'b0});  // AUIPC
    vecs.push_back('{7'h67, 3'd0, 1, 0, 0,  5, 1'b0});  // JALR
    vecs.push_back('{7'h63, 3'd0, 0, 0, 0,  3, 1'b0});  // BEQ
    vecs.push_back('{7'h63, 3'd4, 2, 0, 0,  5, 1'b0});  // BLT
    vecs.push_back('{7'h63, 3'd2, 0, 0, 3,  3, 1'b1});  // bad branch funct3
    vecs.push_back('{7'h03, 3'd3, 0, 0, 3,  3, 1'b1});  // bad load width
    vecs.push_back('{7'h23, 3'd3, 0, 0, 3,  3, 1'b1});  // bad store width
    vecs.push_back('{7'h37, 3'd0, 1, 0, 0,  5, 1'b0});  // LUI
    vecs.push_back('{7'h13, 3'd1, 0, 0, 0,  4, 1'b0});  // SLLI
    vecs.push_back('{7'h13, 3'd0, 0, 0, 0,  4, 1'b0});  // ADDI
    vecs.push_back('{7'h6F, 3'd0, 0, 0, 0,  4, 1'b0});  // JAL
    vecs.push_back('{7'h23, 3'd1, 0, 2, 0,  6, 1'b0});  // SH with waits
    vecs.push_back('{7'h03, 3'd5, 0, 1, 0,  6, 1'b0});  // LHU

    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    do_cycle(0, 1'b0, 2'd0);

    foreach (vecs[i]) begin
      run_instr(vecs[i].opc, vecs[i].f3, vecs[i].wf, vecs[i].wm, vecs[i].hold, flt);
      if (!flt) check_int($sformatf("cycles op=%h", vecs[i].opc), n_cyc, vecs[i].exp_cycles);
      else      check_int($sformatf("cycles-to-fault op=%h", vecs[i].opc), n_cyc, vecs[i].exp_cycles);
      check_int($sformatf("faulted op=%h", vecs[i].opc), int'(flt), int'(vecs[i].exp_fault));
      check_int($sformatf("retire count op=%h", vecs[i].opc), n_ret, vecs[i].exp_fault ? 0 : 1);
      check_int($sformatf("reg_write count op=%h", vecs[i].opc), n_rw,
                (vecs[i].exp_fault || vecs[i].opc == 7'h23 || vecs[i].opc == 7'h63) ? 0 : 1);
      if (flt) do_reset();
    end

    // Reset during an MRD wait aborts the load without any write.
    opcode = 7'h03; funct3 = 3'd2;
    do_cycle(0, 1'b1, 2'd0);
    do_cycle(1, 1'b0, 2'd0);
    do_cycle(2, 1'b1, 2'd0);
    do_cycle(3, 1'b0, 2'd0);
    RSTn = 1'b0; mem_ready = 1'b1;
    @(negedge CLK);
    RSTn = 1'b1;
    n_rw = 0;
    do_cycle(0, 1'b0, 2'd0);
    check_int("abort reg_write", n_rw, 0);

`ifdef MC_CONTROL_TIMEOUT_EN
    for (int k = 0; k < 5; k++) do_cycle(0, 1'b0, 2'd0);
    do_cycle(16, 1'b0, 2'd2);
    do_reset();
    for (int k = 0; k < 4; k++) do_cycle(0, 1'b0, 2'd0);
    do_cycle(0, 1'b1, 2'd0);
    do_cycle(1, 1'b0, 2'd0);
    do_reset();
    opcode = 7'h23; funct3 = 3'd2;
    do_cycle(0, 1'b1, 2'd0);
    do_cycle(1, 1'b0, 2'd0);
    do_cycle(2, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) do_cycle(5, 1'b0, 2'd0);
    do_cycle(16, 1'b1, 2'd2);
    do_reset();
`else
    for (int k = 0; k < 300; k++) do_cycle(0, 1'b0, 2'd0);
    do_reset();
`endif

    for (int n = 0; n < 200; n++) begin
      idx = $urandom_range(0, 9);
      op  = (idx == 9) ? 7'($urandom_range(0, 127)) : ops[idx];
      f3  = 3'($urandom_range(0, 7));
      run_instr(op, f3, $urandom_range(0, 3), $urandom_range(0, 3), 2, flt);
      check_int($sformatf("random retire op=%h f3=%0d", op, f3), n_ret, flt ? 0 : 1);
      if (flt) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
